keypad_scanner: RTL

Reader for a 4x4 active-low matrix keypad; the input-side counterpart of the multiplexed 7-segment digit scanner.
- Drives one column low at a time and samples the row lines.
- Debounces presses and releases, then reports a 4-bit key code with single-cycle event pulses.
- Sits between the board keypad pins and the alarm control FSM, replacing direct raw button sampling.

---
 rtl/keypad_scanner.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Reader for a 4x4 active-low matrix keypad. Drives one column low at a
//   time, samples the row lines through a 2-flop synchronizer, debounces
//   presses and releases on a slow scan tick and reports a 4-bit key code
//   (row_idx*4 + col_idx) with single-cycle event pulses.
//
// Optional feature (compile-time macro):
//   KEYPAD_AUTOREPEAT_EN - while a key stays held, key_valid re-pulses after
//                          REPEAT_DELAY ticks and then every REPEAT_RATE
//                          ticks. Undefined: one key_valid per accepted press.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst         in   asynchronous reset, active low (0 = reset)
//   row_in      in   [3:0] keypad rows, active low, asynchronous to clk
//   col_out     out  [3:0] column drive, active-low one-hot
//   key_code    out  [3:0] code of the last accepted key
//   key_valid   out  1-cycle pulse on acceptance (and on each auto-repeat)
//   key_held    out  high from acceptance until the release is accepted
//   key_release out  1-cycle pulse when a release is accepted
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } state_t;

  localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DEB_MAX = 8'(DEBOUNCE_TICKS);

  // Column index from the active-low one-hot drive pattern.
  function automatic logic [1:0] col_index(input logic [3:0] col);
    case (col)
      4'b0111: col_index = 2'd3;
      4'b1011: col_index = 2'd2;
      4'b1101: col_index = 2'd1;
      default: col_index = 2'd0;
    endcase
  endfunction

  // Lowest-numbered low row wins when several rows are pulled low.
  function automatic logic [1:0] prio_row(input logic [3:0] rows);
    if      (!rows[0]) prio_row = 2'd0;
    else if (!rows[1]) prio_row = 2'd1;
    else if (!rows[2]) prio_row = 2'd2;
    else               prio_row = 2'd3;
  endfunction

  // -------------------------------------------------------------------------
  // Row synchronizer. Idle (released) rows read high, so reset to all ones.
  // -------------------------------------------------------------------------
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  // NOTE: every clocked block uses non-blocking (<=) assignments so that all
  // flops sample their inputs from the same pre-edge values; blocking
  // assignments here would turn the two-stage synchronizer into a single flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= row_in;
      r_sync2 <= r_sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Scan tick divider: counts 0..SCAN_DIV-1, tick on the terminal count.
  // -------------------------------------------------------------------------
  logic [15:0] r_div;
  logic        w_tick;

  assign w_tick = (r_div == DIV_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Scan / debounce FSM with registered outputs.
  // -------------------------------------------------------------------------
  state_t     r_state;
  logic [3:0] r_col;
  logic [1:0] r_row_idx;
  logic [1:0] r_col_idx;
  logic [7:0] r_cnt;
  logic [3:0] r_key_code;
  logic       r_key_valid;
  logic       r_key_held;
  logic       r_key_release;
  logic       w_row_low;
  logic [3:0] w_col_next;

  // Only the latched row matters once a key is being tracked; presses on
  // other rows or columns are ignored (no rollover).
  assign w_row_low  = ~r_sync2[r_row_idx];
  // Rotate 0111 -> 1011 -> 1101 -> 1110 -> 0111.
  assign w_col_next = {r_col[0], r_col[3:1]};

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [9:0] REP_DELAY = 10'(REPEAT_DELAY);
  localparam logic [9:0] REP_RATE  = 10'(REPEAT_RATE);

  // Ticks spent in HELD since acceptance or since the last repeat pulse.
  // Frozen while in DEB_REL so a release bounce does not restart the delay.
  logic [9:0] r_rep;
  logic       r_rep_first;
  logic [9:0] w_rep_next;
  logic       w_rep_hit;

  assign w_rep_next = r_rep + 10'd1;
  assign w_rep_hit  = (w_rep_next == (r_rep_first ? REP_DELAY : REP_RATE));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_SCAN;
      r_col         <= 4'b0111;
      r_row_idx     <= 2'd0;
      r_col_idx     <= 2'd0;
      r_cnt         <= 8'd0;
      r_key_code    <= 4'd0;
      r_key_valid   <= 1'b0;
      r_key_held    <= 1'b0;
      r_key_release <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep         <= 10'd0;
      r_rep_first   <= 1'b1;
`endif
    end else begin
      // Event outputs are single-cycle pulses: cleared unless re-asserted.
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;

      if (w_tick) begin
        case (r_state)
          ST_SCAN: begin
            if (r_sync2 == 4'b1111) begin
              r_col <= w_col_next;
            end else begin
              r_row_idx <= prio_row(r_sync2);
              r_col_idx <= col_index(r_col);
              r_cnt     <= 8'd1;
              r_state   <= ST_DEB_PRESS;
            end
          end

          ST_DEB_PRESS: begin
            if (w_row_low) begin
              if (r_cnt == DEB_MAX) begin
                r_key_code  <= {r_row_idx, r_col_idx};
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_state     <= ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                r_rep       <= 10'd0;
                r_rep_first <= 1'b1;
`endif
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end else begin
              r_col   <= w_col_next;
              r_state <= ST_SCAN;
            end
          end

          ST_HELD: begin
            if (!w_row_low) begin
              r_cnt   <= 8'd1;
              r_state <= ST_DEB_REL;
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
              if (w_rep_hit) begin
                r_key_valid <= 1'b1;
                r_rep       <= 10'd0;
                r_rep_first <= 1'b0;
              end else begin
                r_rep <= w_rep_next;
              end
`endif
            end
          end

          ST_DEB_REL: begin
            if (!w_row_low) begin
              if (r_cnt == DEB_MAX) begin
                r_key_held    <= 1'b0;
                r_key_release <= 1'b1;
                r_col         <= w_col_next;
                r_state       <= ST_SCAN;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end else begin
              r_state <= ST_HELD;
            end
          end

          default: r_state <= ST_SCAN;
        endcase
      end
    end
  end

  assign col_out     = r_col;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_held    = r_key_held;
  assign key_release = r_key_release;

endmodule
